// File: rtl/sparse_conv_pe_lanes_pkg.sv
// Shared widths, sizes and state encoding for the multi-lane sparse convolution PE.
package sparse_conv_pe_lanes_pkg;
    localparam int COL_LENGTH         = 8;
    localparam int WORD_LENGTH        = 8;
    localparam int DOUBLE_WORD_LENGTH = 16;
    localparam int KERNEL_SIZE        = 5;
    localparam int IMAGE_SIZE         = 28;
    localparam int OUT_SIZE           = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int MAX_FEATURES       = 784;
    localparam int MAX_WEIGHTS        = 28;
    localparam int LANES              = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pe_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction
endpackage

// File: rtl/sparse_conv_pe_lanes_mac_lane.sv
// One lane: signed product plus output-plane coordinate and range check.
module sparse_mac_lane #(
    parameter int word_length = 8,
    parameter int col_length  = 8,
    parameter int out_size    = 24
) (
    input  logic signed [word_length-1:0]   f_value,
    input  logic signed [word_length-1:0]   w_value,
    input  logic        [col_length-1:0]    f_row,
    input  logic        [col_length-1:0]    f_col,
    input  logic        [col_length-1:0]    w_row,
    input  logic        [col_length-1:0]    w_col,
    input  logic                            f_live,
    output logic signed [2*word_length-1:0] product,
    output logic        [col_length-1:0]    row,
    output logic        [col_length-1:0]    col,
    output logic                            mask
);
    localparam logic signed [col_length:0] OUT_LIM = (col_length + 1)'(out_size);

    logic signed [col_length:0]       r;
    logic signed [col_length:0]       c;
    logic signed [2*word_length-1:0]  full_product;

    assign r = $signed({1'b0, f_row}) - $signed({1'b0, w_row});
    assign c = $signed({1'b0, f_col}) - $signed({1'b0, w_col});
    assign full_product = f_value * w_value;

    assign mask    = f_live && !r[col_length] && (r < OUT_LIM) && !c[col_length] && (c < OUT_LIM);
    assign product = mask ? full_product : '0;
    assign row     = mask ? r[col_length-1:0] : '0;
    assign col     = mask ? c[col_length-1:0] : '0;
endmodule

// File: rtl/sparse_conv_pe_lanes.sv
// Walks the weight x feature cross-product LANES features per beat and streams
// masked signed partial products with output-plane coordinates.
//   state | meaning
//   IDLE  | waiting for a job, in_ready high
//   RUN   | issuing beats from the wi/fg counters into the output register
//   DRAIN | final beat issued, waiting for its handshake
module sparse_conv_pe_lanes
    import sparse_conv_pe_lanes_pkg::*;
#(
    parameter int col_length         = COL_LENGTH,
    parameter int word_length        = WORD_LENGTH,
    parameter int double_word_length = DOUBLE_WORD_LENGTH,
    parameter int kernel_size        = KERNEL_SIZE,
    parameter int image_size         = IMAGE_SIZE,
    parameter int max_features       = MAX_FEATURES,
    parameter int max_weights        = MAX_WEIGHTS,
    parameter int lanes              = LANES
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [double_word_length-1:0]         in_channel,
    input  logic [double_word_length-1:0]         feature_valid_num,
    input  logic [max_features*word_length-1:0]   feature_value,
    input  logic [max_features*col_length-1:0]    feature_cols,
    input  logic [max_features*col_length-1:0]    feature_rows,
    input  logic [double_word_length-1:0]         weight_valid_num,
    input  logic [max_weights*word_length-1:0]    weight_value,
    input  logic [max_weights*col_length-1:0]     weight_cols,
    input  logic [max_weights*col_length-1:0]     weight_rows,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [lanes*2*word_length-1:0]        data_out,
    output logic [lanes*col_length-1:0]           data_out_cols,
    output logic [lanes*col_length-1:0]           data_out_rows,
    output logic [lanes-1:0]                      data_out_mask,
    output logic [double_word_length-1:0]         out_channel,
    output logic                                  out_last,
    output logic                                  done
);
    localparam int PW       = 2 * word_length;
    localparam int DW       = double_word_length;
    localparam int OUT_EDGE = image_size - kernel_size + 1;

    pe_state_t      state_q, state_d;
    logic [DW-1:0]  wn_q, fn_q, ch_q, wi_q, fg_q, ng;
    logic           accept, advance, job_empty, beat_last;
    int             wsel;

    logic [PW-1:0]          lane_prod [lanes];
    logic [col_length-1:0]  lane_row  [lanes];
    logic [col_length-1:0]  lane_col  [lanes];
    logic                   lane_mask [lanes];

    assign in_ready    = (state_q == IDLE);
    assign accept      = in_valid && in_ready;
    assign advance     = !out_valid || out_ready;
    assign ng          = DW'(ceil_div(int'(fn_q), lanes));
    assign job_empty   = (wn_q == '0) || (fn_q == '0);
    assign beat_last   = (wi_q == wn_q - DW'(1)) && (fg_q == ng - DW'(1));
    assign out_channel = ch_q;
    assign wsel        = (int'(wi_q) < max_weights) ? int'(wi_q) : 0;

    for (genvar l = 0; l < lanes; l++) begin : g_lane
        int fi, fsel;

        // fsel only keeps the part-select in range; out-of-list lanes are masked by f_live
        always_comb begin
            fi   = int'(fg_q) * lanes + l;
            fsel = (fi < max_features) ? fi : 0;
        end

        sparse_mac_lane #(
            .word_length (word_length),
            .col_length  (col_length),
            .out_size    (OUT_EDGE)
        ) u_lane (
            .f_value (feature_value[fsel*word_length +: word_length]),
            .w_value (weight_value[wsel*word_length +: word_length]),
            .f_row   (feature_rows[fsel*col_length +: col_length]),
            .f_col   (feature_cols[fsel*col_length +: col_length]),
            .w_row   (weight_rows[wsel*col_length +: col_length]),
            .w_col   (weight_cols[wsel*col_length +: col_length]),
            .f_live  (fi < int'(fn_q)),
            .product (lane_prod[l]),
            .row     (lane_row[l]),
            .col     (lane_col[l]),
            .mask    (lane_mask[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN: begin
                if (job_empty)                  state_d = IDLE;
                else if (advance && beat_last)  state_d = DRAIN;
            end
            DRAIN:   if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wn_q <= '0;
            fn_q <= '0;
            ch_q <= '0;
            wi_q <= '0;
            fg_q <= '0;
            done <= 1'b0;
        end else begin
            done <= ((state_q == RUN) && job_empty) ||
                    ((state_q == DRAIN) && out_valid && out_ready);
            if (accept) begin
                wn_q <= (weight_valid_num > DW'(max_weights)) ? DW'(max_weights) : weight_valid_num;
                fn_q <= (feature_valid_num > DW'(max_features)) ? DW'(max_features) : feature_valid_num;
                ch_q <= in_channel;
                wi_q <= '0;
                fg_q <= '0;
            end else if ((state_q == RUN) && !job_empty && advance) begin
                if (fg_q == ng - DW'(1)) begin
                    fg_q <= '0;
                    wi_q <= wi_q + DW'(1);
                end else begin
                    fg_q <= fg_q + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            data_out      <= '0;
            data_out_rows <= '0;
            data_out_cols <= '0;
            data_out_mask <= '0;
        end else if (advance) begin
            if ((state_q == RUN) && !job_empty) begin
                out_valid <= 1'b1;
                out_last  <= beat_last;
                for (int l = 0; l < lanes; l++) begin
                    data_out[l*PW +: PW]                 <= lane_prod[l];
                    data_out_rows[l*col_length +: col_length] <= lane_row[l];
                    data_out_cols[l*col_length +: col_length] <= lane_col[l];
                    data_out_mask[l]                     <= lane_mask[l];
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sparse_conv_pe_lanes.sv
// Self-checking bench: hand-computed vectors, directed corner sequences and random jobs
// against a cross-product reference model.
module tb_sparse_conv_pe_lanes;
    localparam int MAXF = 784;
    localparam int MAXW = 28;
    localparam int LN   = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] rows;
        logic [31:0] cols;
        logic [3:0]  mask;
        logic        last;
    } beat_t;

    typedef struct {
        int               fn;
        logic [7:0]       wv, wr, wc;
        logic [3:0][7:0]  fv, fr, fc;
        beat_t            exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out_last, done;
    logic [15:0] in_channel = '0, feature_valid_num = '0, weight_valid_num = '0, out_channel;
    logic [MAXF*8-1:0] feature_value = '0, feature_cols = '0, feature_rows = '0;
    logic [MAXW*8-1:0] weight_value = '0, weight_cols = '0, weight_rows = '0;
    logic [63:0] data_out;
    logic [31:0] data_out_cols, data_out_rows;
    logic [3:0]  data_out_mask;

    logic signed [7:0] fv [MAXF];
    logic        [7:0] fr [MAXF];
    logic        [7:0] fc [MAXF];
    logic signed [7:0] wv [MAXW];
    logic        [7:0] wr [MAXW];
    logic        [7:0] wc [MAXW];

    beat_t exp_q [$];
    vec_t  vecs [5];
    logic [3:0] masks_seen [64];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sparse_conv_pe_lanes dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_channel(in_channel), .feature_valid_num(feature_valid_num),
        .feature_value(feature_value), .feature_cols(feature_cols), .feature_rows(feature_rows),
        .weight_valid_num(weight_valid_num), .weight_value(weight_value),
        .weight_cols(weight_cols), .weight_rows(weight_rows),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .data_out_cols(data_out_cols), .data_out_rows(data_out_rows),
        .data_out_mask(data_out_mask), .out_channel(out_channel),
        .out_last(out_last), .done(done)
    );

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_bus();
        for (int i = 0; i < MAXF; i++) begin
            feature_value[i*8 +: 8] = fv[i];
            feature_rows[i*8 +: 8]  = fr[i];
            feature_cols[i*8 +: 8]  = fc[i];
        end
        for (int i = 0; i < MAXW; i++) begin
            weight_value[i*8 +: 8] = wv[i];
            weight_rows[i*8 +: 8]  = wr[i];
            weight_cols[i*8 +: 8]  = wc[i];
        end
    endtask

    // Reference: every weight against every feature, grouped LN at a time.
    task automatic build_model(input int wn, input int fn);
        int wnc, fnc, ng, fi, r, c;
        beat_t b;
        wnc = (wn > MAXW) ? MAXW : wn;
        fnc = (fn > MAXF) ? MAXF : fn;
        ng  = (fnc + LN - 1) / LN;
        exp_q.delete();
        for (int w = 0; w < wnc; w++) begin
            for (int g = 0; g < ng; g++) begin
                b = '0;
                for (int l = 0; l < LN; l++) begin
                    fi = g * LN + l;
                    if (fi < fnc) begin
                        r = int'(fr[fi]) - int'(wr[w]);
                        c = int'(fc[fi]) - int'(wc[w]);
                        if (r >= 0 && r < 24 && c >= 0 && c < 24) begin
                            b.data[l*16 +: 16] = 16'(int'(fv[fi]) * int'(wv[w]));
                            b.rows[l*8 +: 8]   = 8'(r);
                            b.cols[l*8 +: 8]   = 8'(c);
                            b.mask[l]          = 1'b1;
                        end
                    end
                end
                b.last = (w == wnc - 1) && (g == ng - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low 3 cycles when beat stall_beat appears
    task automatic run_job(input int wn, input int fn, input int ch, input int mode, input int stall_beat);
        int beats, first_v, last_hs, done_cyc, stall_cnt, n_exp;
        bit held_valid;
        beat_t held, cur, e;
        n_exp = exp_q.size();
        beats = 0; first_v = -1; last_hs = -1; done_cyc = -1; stall_cnt = 0; held_valid = 0;
        weight_valid_num  = 16'(wn);
        feature_valid_num = 16'(fn);
        in_channel        = 16'(ch);
        in_valid          = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (mode == 1)
                out_ready = 1'($urandom_range(0, 1));
            else if (mode == 2 && out_valid && beats == stall_beat && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else
                out_ready = 1'b1;
            cur = {data_out, data_out_rows, data_out_cols, data_out_mask, out_last};
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (held_valid) check("stall_hold", cur, held);
                if (out_ready) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("beat", cur, e);
                    end
                    check("channel", out_channel, 16'(ch));
                    if (beats < 64) masks_seen[beats] = data_out_mask;
                    beats++;
                    last_hs = cyc;
                    held_valid = 0;
                end else begin
                    held = cur;
                    held_valid = 1;
                end
            end else begin
                if (held_valid) check("valid_dropped", out_valid, 1'b1);
                held_valid = 0;
            end
        end
        check("beat_count", beats, n_exp);
        if (n_exp > 0) begin
            check("first_valid_cycle", first_v, 2);
            check("done_cycle", done_cyc, last_hs + 1);
        end else begin
            check("done_cycle_empty", done_cyc, 2);
        end
        @(negedge clk);
        check("done_pulse_width", done, 1'b0);
        check("ready_after_job", in_ready, 1'b1);
        out_ready = 1'b1;
    endtask

    task automatic set_vec(input int i, input int fn, input logic [7:0] wv_, input logic [7:0] wr_,
                           input logic [7:0] wc_, input logic [31:0] fv_, input logic [31:0] fr_,
                           input logic [31:0] fc_, input logic [63:0] d, input logic [31:0] rr,
                           input logic [31:0] cc, input logic [3:0] m);
        vecs[i].fn = fn;
        vecs[i].wv = wv_; vecs[i].wr = wr_; vecs[i].wc = wc_;
        vecs[i].fv = fv_; vecs[i].fr = fr_; vecs[i].fc = fc_;
        vecs[i].exp = {d, rr, cc, m, 1'b1};
    endtask

    task automatic randomize_lists();
        for (int i = 0; i < MAXF; i++) begin
            fv[i] = 8'($urandom);
            fr[i] = 8'($urandom_range(0, 31));
            fc[i] = 8'($urandom_range(0, 31));
        end
        for (int i = 0; i < MAXW; i++) begin
            wv[i] = 8'($urandom);
            wr[i] = 8'($urandom_range(0, 6));
            wc[i] = 8'($urandom_range(0, 6));
        end
    endtask

    initial begin
        // lane 0 in the low slice of every packed field
        set_vec(0, 4, 8'd3, 8'd0, 8'd0, {8'd4, 8'hFD, 8'd2, 8'd1}, {8'd23, 8'd5, 8'd0, 8'd0},
                {8'd23, 8'd5, 8'd1, 8'd0}, {16'd12, 16'hFFF7, 16'd6, 16'd3},
                {8'd23, 8'd5, 8'd0, 8'd0}, {8'd23, 8'd5, 8'd1, 8'd0}, 4'b1111);
        set_vec(1, 3, 8'd2, 8'd4, 8'd4, {8'd0, 8'd7, 8'hFF, 8'd5}, {8'd0, 8'd4, 8'd27, 8'd2},
                {8'd0, 8'd28, 8'd27, 8'd2}, {16'd0, 16'd0, 16'hFFFE, 16'd0},
                {8'd0, 8'd0, 8'd23, 8'd0}, {8'd0, 8'd0, 8'd23, 8'd0}, 4'b0010);
        set_vec(2, 2, 8'h80, 8'd0, 8'd0, {8'd0, 8'd0, 8'd127, 8'h80}, {8'd0, 8'd0, 8'd3, 8'd1},
                {8'd0, 8'd0, 8'd4, 8'd2}, {16'd0, 16'd0, 16'hC080, 16'h4000},
                {8'd0, 8'd0, 8'd3, 8'd1}, {8'd0, 8'd0, 8'd4, 8'd2}, 4'b0011);
        set_vec(3, 4, 8'd1, 8'd0, 8'd0, {8'd0, 8'hFF, 8'd5, 8'd5}, {8'd0, 8'd23, 8'd0, 8'd24},
                {8'd0, 8'd0, 8'd24, 8'd0}, {16'd0, 16'hFFFF, 16'd0, 16'd0},
                {8'd0, 8'd23, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 4'b1100);
        set_vec(4, 2, 8'd9, 8'd27, 8'd27, {8'd0, 8'd0, 8'd1, 8'd3}, {8'd0, 8'd0, 8'd26, 8'd27},
                {8'd0, 8'd0, 8'd27, 8'd27}, {16'd0, 16'd0, 16'd0, 16'd27},
                {8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0001);

        randomize_lists();
        load_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_outputs", {data_out, data_out_rows, data_out_cols, data_out_mask, out_last, out_channel}, '0);
        out_ready = 1'b1;

        for (int v = 0; v < 5; v++) begin
            for (int l = 0; l < LN; l++) begin
                fv[l] = vecs[v].fv[l];
                fr[l] = vecs[v].fr[l];
                fc[l] = vecs[v].fc[l];
            end
            wv[0] = vecs[v].wv; wr[0] = vecs[v].wr; wc[0] = vecs[v].wc;
            load_bus();
            exp_q.delete();
            exp_q.push_back(vecs[v].exp);
            run_job(1, vecs[v].fn, 7 + v, 0, -1);
        end

        // two weights, five features: two groups per weight, stall on the second beat
        for (int i = 0; i < 5; i++) begin
            fv[i] = 8'(i + 1);
            fr[i] = 8'(i + 5);
            fc[i] = 8'(i + 5);
        end
        wv[0] = 8'd2;  wr[0] = 8'd0; wc[0] = 8'd0;
        wv[1] = 8'hFD; wr[1] = 8'd1; wc[1] = 8'd1;
        load_bus();
        build_model(2, 5);
        run_job(2, 5, 16'h55, 2, 1);
        check("mask_sequence", {masks_seen[0], masks_seen[1], masks_seen[2], masks_seen[3]},
              {4'b1111, 4'b0001, 4'b1111, 4'b0001});

        // empty jobs: no beats, done two cycles after accept
        exp_q.delete();
        run_job(0, 3, 16'h21, 0, -1);
        exp_q.delete();
        run_job(2, 0, 16'h22, 0, -1);

        // reset in the middle of a job
        randomize_lists();
        load_bus();
        weight_valid_num = 16'd3; feature_valid_num = 16'd8; in_channel = 16'h33;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_done", done, 1'b0);
        @(negedge clk);
        check("midrst_no_done", done, 1'b0);
        build_model(3, 8);
        run_job(3, 8, 16'h34, 0, -1);

        // random jobs against the model under random backpressure
        for (int j = 0; j < 8; j++) begin
            int wn, fn;
            wn = $urandom_range(1, 4);
            fn = $urandom_range(1, 12);
            randomize_lists();
            load_bus();
            build_model(wn, fn);
            run_job(wn, fn, 16'h100 + j, 1, -1);
        end

        // counts above capacity are clamped
        randomize_lists();
        load_bus();
        build_model(30, 2);
        run_job(30, 2, 16'h200, 0, -1);
        build_model(1, 900);
        run_job(1, 900, 16'h201, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
